alu_op_queue: RTL and testbench



---
 rtl/alu_op_queue.sv | 146 ++++++++++++++
 tb/tb_alu_op_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_queue.sv
// alu_op_queue: in-order FIFO of resolved ALU operations between decode and execute.
// The head entry drives the ALU input buses directly. A synchronous flush discards
// every queued op on a branch redirect.
// Optional feature: define ALU_Q_BYPASS_EN so that an op arriving at an empty queue
// appears on the outputs in the same cycle. That op is consumed without being
// stored when out_ready is high.

module alu_op_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  // upstream (decode) side
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_mode,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic                     in_cin,
  input  logic [TAG_W-1:0]         in_tag,
  // downstream (ALU / writeback) side
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_mode,
  output logic [31:0]              out_a,
  output logic [31:0]              out_b,
  output logic                     out_cin,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Entry storage, one array per payload field
  logic [2:0]       mode_q [DEPTH];
  logic [31:0]      a_q    [DEPTH];
  logic [31:0]      b_q    [DEPTH];
  logic             cin_q  [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];

  logic [PtrW-1:0] wp_q, wp_d;
  logic [PtrW-1:0] rp_q, rp_d;
  logic [CntW-1:0] count_q, count_d;

  logic head_valid;
  logic push;
  logic pop;
  logic bypass;
  logic store;

  // Handshake qualification. in_ready looks only at the registered count, so ready
  // never depends combinationally on out_ready.
  always_comb begin
    in_ready   = (count_q < CntW'(DEPTH));
    head_valid = (count_q != '0);
    push       = in_valid & in_ready & ~flush;
    pop        = head_valid & out_ready & ~flush;
    bypass     = 1'b0;
`ifdef ALU_Q_BYPASS_EN
    bypass     = ~head_valid & in_valid & ~flush;
`endif
    // A bypassed op that is consumed at once never occupies a slot
    store      = push & ~(bypass & out_ready);
  end

  // Pointer and occupancy next state; flush overrides any push or pop
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (store) wp_d = wp_q + PtrW'(1);
      if (pop)   rp_d = rp_q + PtrW'(1);
      case ({store, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Entry storage write; cleared on reset so nothing stale can ever be observed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mode_q[i] <= '0;
        a_q[i]    <= '0;
        b_q[i]    <= '0;
        cin_q[i]  <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else if (store) begin
      mode_q[wp_q] <= in_mode;
      a_q[wp_q]    <= in_a;
      b_q[wp_q]    <= in_b;
      cin_q[wp_q]  <= in_cin;
      tag_q[wp_q]  <= in_tag;
    end
  end

  // Head presentation: stored head, else the bypassed input, else all zeros
  always_comb begin
    out_valid = head_valid | bypass;
    out_mode  = '0;
    out_a     = '0;
    out_b     = '0;
    out_cin   = 1'b0;
    out_tag   = '0;
    if (head_valid) begin
      out_mode = mode_q[rp_q];
      out_a    = a_q[rp_q];
      out_b    = b_q[rp_q];
      out_cin  = cin_q[rp_q];
      out_tag  = tag_q[rp_q];
    end else if (bypass) begin
      out_mode = in_mode;
      out_a    = in_a;
      out_b    = in_b;
      out_cin  = in_cin;
      out_tag  = in_tag;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_alu_op_queue.sv
// Directed self-checking bench for alu_op_queue (DEPTH=4, TAG_W=5).
// Inputs change 1 time unit after the rising edge; outputs are sampled in the same slot.

module tb_alu_op_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_cin;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_mode;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_cin;
  logic [4:0]  out_tag;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  alu_op_queue #(.DEPTH(4), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_cin   (out_cin),
    .out_tag   (out_tag),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_mode = '0; in_a = '0; in_b = '0; in_cin = 1'b0; in_tag = '0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a = 32'd10 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rst_fill_count: got %0d expected 3", count); end
    // Assert reset between edges: effect must be immediate
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL async_rst_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_rst_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_a !== 32'd0 || out_tag !== 5'd0) begin errors++; $display("FAIL async_rst_payload: got a=%h tag=%h expected 0", out_a, out_tag); end
    step();
    rst_n = 1'b1; in_valid = 1'b1; in_a = 32'h55;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_a !== 32'h55) begin errors++; $display("FAIL post_rst_push: got v=%b a=%h expected v=1 a=55", out_valid, out_a); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL post_rst_count: got %0d expected 1", count); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_a = 32'(i);
      step();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    in_a = 32'd5;
    step();
    checks++; if (count !== 3'd4 || out_a !== 32'd1) begin errors++; $display("FAIL full_hold: got count=%0d a=%0d expected count=4 a=1", count, out_a); end
    out_ready = 1'b1;
    // Expected head sequence 1..5 with the 5th accepted in the cycle after the first pop
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || out_a !== 32'(k + 1)) begin errors++; $display("FAIL drain_%0d: got v=%b a=%0d expected v=1 a=%0d", k, out_valid, out_a, k + 1); end
      if (k == 1) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_accept: got in_ready=%b expected 1", in_ready); end
      end
      step();
      if (k == 1) in_valid = 1'b0;
    end
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drain_empty: got v=%b count=%0d expected v=0 count=0", out_valid, count); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1;
    in_a = 32'd100; step();
    in_a = 32'd101; step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_a = 32'd102 + 32'(i);
      #1;
      checks++; if (out_a !== 32'd100 + 32'(i) || count !== 3'd2) begin errors++; $display("FAIL b2b_%0d: got a=%0d count=%0d expected a=%0d count=2", i, out_a, count, 100 + i); end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_a !== 32'd110 || count !== 3'd2) begin errors++; $display("FAIL b2b_wrap: got a=%0d count=%0d expected a=110 count=2", out_a, count); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 32'd20 + 32'(i);
      step();
    end
    in_a = 32'd99; out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_state: got count=%0d v=%b expected count=0 v=0", count, out_valid); end
    checks++; if (in_ready !== 1'b1 || out_a !== 32'd0) begin errors++; $display("FAIL flush_ready: got rdy=%b a=%h expected rdy=1 a=0", in_ready, out_a); end
    in_valid = 1'b1; in_a = 32'd7;
    step();
    in_valid = 1'b0;
    checks++; if (out_a !== 32'd7 || count !== 3'd1) begin errors++; $display("FAIL flush_after: got a=%0d count=%0d expected a=7 count=1", out_a, count); end
  endtask

  task automatic test_payload();
    do_reset();
    in_valid = 1'b1; in_mode = 3'b110; in_a = 32'h8000_0000; in_b = 32'h7FFF_FFFF;
    in_cin = 1'b1; in_tag = 5'd31;
    step();
    in_valid = 1'b0; in_mode = '0; in_a = '0; in_b = '0; in_cin = 1'b0; in_tag = '0;
    checks++; if (out_mode !== 3'b110 || out_a !== 32'h8000_0000 || out_b !== 32'h7FFF_FFFF || out_cin !== 1'b1 || out_tag !== 5'd31) begin
      errors++; $display("FAIL payload: got m=%b a=%h b=%h c=%b t=%0d expected m=110 a=80000000 b=7fffffff c=1 t=31", out_mode, out_a, out_b, out_cin, out_tag);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_mode !== 3'd0 || out_a !== 32'd0 || out_b !== 32'd0 || out_cin !== 1'b0 || out_tag !== 5'd0) begin
      errors++; $display("FAIL payload_zero: got v=%b m=%b a=%h b=%h c=%b t=%0d expected all 0", out_valid, out_mode, out_a, out_b, out_cin, out_tag);
    end
  endtask

`ifdef ALU_Q_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1; in_a = 32'hDEAD_BEEF;
    #1;
    checks++; if (out_valid !== 1'b1 || out_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same_cycle: got v=%b a=%h expected v=1 a=deadbeef", out_valid, out_a); end
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bypass_consumed: got count=%0d v=%b expected count=0 v=0", count, out_valid); end
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd1 || out_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_stored: got count=%0d a=%h expected count=1 a=deadbeef", count, out_a); end
  endtask
`else
  task automatic test_latency();
    do_reset();
    in_valid = 1'b1; out_ready = 1'b0; in_a = 32'hDEAD_BEEF;
    #1;
    checks++; if (out_valid !== 1'b0 || out_a !== 32'd0) begin errors++; $display("FAIL latency_same_cycle: got v=%b a=%h expected v=0 a=0", out_valid, out_a); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_a !== 32'hDEAD_BEEF || count !== 3'd1) begin errors++; $display("FAIL latency_next: got v=%b a=%h count=%0d expected v=1 a=deadbeef count=1", out_valid, out_a, count); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_mode = '0; in_a = '0; in_b = '0; in_cin = 1'b0; in_tag = '0;
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_payload();
`ifdef ALU_Q_BYPASS_EN
    test_bypass();
`else
    test_latency();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
